oam_dma_arbiter: RTL

- Sits between the CPU external bus (`addr_ext`/`data_ext`, `mem_we`/`mem_re`) and the single-port memory system.
- Owns the OAM DMA register at 16'hFF46. A CPU write of XX copies LENGTH bytes from {XX,8'h00} onward to 16'hFE00 onward.
- Arbitrates the one memory port between the CPU and the DMA engine. The DMA engine has priority unless the optional cycle-steal mode is compiled in.

---
 rtl/oam_dma_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: shares one memory port between the CPU and the OAM DMA engine (register at DMA_REG_ADDR).
// Define DMA_CYCLE_STEAL_EN to let CPU accesses pre-empt the DMA instead of being blocked.
module oam_dma_arbiter #(
   parameter int          LENGTH       = 160,
   parameter int          START_DELAY  = 1,
   parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
   parameter logic [15:0] DST_BASE     = 16'hFE00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        dma_busy
);
   typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;
   state_t state, state_nx;
   logic [7:0] src_hi, idx, data_q;
   logic [3:0] dly;
   logic hit, trig, active, stall, last, pass;
   assign hit      = cpu_addr == DMA_REG_ADDR;
   assign trig     = cpu_we && hit;
   assign active   = state == READ || state == WRITE;
   assign last     = idx == 8'(LENGTH - 1);
   assign dma_busy = state != IDLE;
`ifdef DMA_CYCLE_STEAL_EN
   assign stall = active && (cpu_re || cpu_we) && !hit;
`else
   assign stall = 1'b0;
`endif
   assign pass = !active || stall;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state  <= IDLE;
         src_hi <= 8'h00;
         idx    <= 8'h00;
         dly    <= 4'd0;
         data_q <= 8'h00;
      end else begin
         state <= state_nx;
         if (trig) begin
            src_hi <= cpu_wdata;
            idx    <= 8'h00;
            dly    <= 4'(START_DELAY);
         end else if (state == DELAY) dly <= dly - 4'd1;
         else if (!stall && state == READ) data_q <= mem_rdata;
         else if (!stall && state == WRITE && !last) idx <= idx + 8'd1;
      end
   always_comb begin
      state_nx = state;
      if (trig) state_nx = START_DELAY == 0 ? READ : DELAY;
      else if (!stall)
         state_nx = state == DELAY ? (dly == 4'd1 ? READ : DELAY) :
                    state == READ  ? WRITE :
                    state == WRITE ? (last ? IDLE : READ) : IDLE;
   end
   // A trigger cycle kills any DMA strobe so the in-flight byte is dropped.
   always_comb begin
      mem_addr  = 16'h0000;
      mem_wdata = 8'h00;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (reset) begin
         if (pass) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we && !hit;
            mem_re    = cpu_re && !cpu_we && !hit;
         end else if (!trig) begin
            mem_addr  = state == READ ? {src_hi, idx} : DST_BASE + {8'h00, idx};
            mem_wdata = data_q;
            mem_we    = state == WRITE;
            mem_re    = state == READ;
         end
      end
      cpu_rdata = hit ? src_hi : pass ? mem_rdata : 8'hFF;
   end
   a_no_rw: assert property (@(posedge clock) disable iff (!reset) !(cpu_re && cpu_we));
endmodule
